// File: rtl/kws_pkg.sv
// kws_pkg: state encodings and channel-tag width helper for the KWS sample ingress
package kws_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/kws_sync_fifo.sv
// kws_sync_fifo: first-word fall-through FIFO with flush, level, full and empty
module kws_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic do_push, do_pop;
  always_comb begin
    full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    empty = wptr == rptr;
    level = wptr - rptr;
    do_push = push && !full && !flush;
    do_pop = pop && !empty && !flush;
    rdata = empty ? '0 : mem[rptr[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop) rptr <= rptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/kws_sample_ingress.sv
// kws_sample_ingress: toggle-framed multi-channel sample capture, FIFO and run sequencer
// Optional KWS_INGRESS_OVFCNT_EN adds a saturating 8-bit dropped-push counter ovf_count.
module kws_sample_ingress
  import kws_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int CHANNELS = 2,
  parameter int FIFO_DEPTH = 8,
  localparam int CH_W = ch_w(CHANNELS),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] la_sample,
  input  logic [CH_W-1:0]     la_chan,
  input  logic                la_toggle,
  input  logic                la_start,
  input  logic                la_clear,
  input  logic                acc_done,
  output logic [SAMPLE_W-1:0] smp_data,
  output logic [CH_W-1:0]     smp_chan,
  output logic                smp_valid,
  input  logic                smp_ready,
  output logic                acc_start,
  output logic                busy,
  output logic                done_sticky,
  output logic                irq,
  output logic [LW-1:0]       fifo_level,
`ifdef KWS_INGRESS_OVFCNT_EN
  output logic [7:0]          ovf_count,
`endif
  output logic                ovf_flag
);
  state_t state;
  logic [2:0] s1, s2, sq;
  logic push_req, start_edge, clr, in_run, chan_bad, full, empty, drop, push, pop;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      sq <= '0;
    end else begin
      s1 <= {la_clear, la_start, la_toggle};
      s2 <= s1;
      sq <= s2;
    end
  always_comb begin
    push_req = s2[0] ^ sq[0];
    start_edge = s2[1] & ~sq[1];
    clr = sq[2];
    in_run = state == RUN;
    chan_bad = int'(la_chan) >= CHANNELS;
    drop = in_run && push_req && (chan_bad || full) && !clr;
    push = in_run && push_req && !chan_bad && !full && !clr;
    smp_valid = in_run && !empty;
    pop = smp_valid && smp_ready;
    busy = in_run;
    irq = done_sticky | ovf_flag;
  end
  kws_sync_fifo #(.WIDTH(SAMPLE_W + CH_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .flush(clr),
    .push(push),
    .pop(pop),
    .wdata({la_chan, la_sample}),
    .rdata({smp_chan, smp_data}),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      acc_start <= 1'b0;
      done_sticky <= 1'b0;
      ovf_flag <= 1'b0;
    end else begin
      acc_start <= 1'b0;
      if (clr) begin
        state <= IDLE;
        done_sticky <= 1'b0;
        ovf_flag <= 1'b0;
      end else begin
        if (drop) ovf_flag <= 1'b1;
        if (state == IDLE && start_edge) begin
          state <= RUN;
          acc_start <= 1'b1;
        end else if (in_run && acc_done) begin
          state <= DONE;
          done_sticky <= 1'b1;
        end
      end
    end
`ifdef KWS_INGRESS_OVFCNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) ovf_count <= '0;
    else if (clr) ovf_count <= '0;
    else if (drop && ovf_count != 8'hff) ovf_count <= ovf_count + 8'd1;
`endif
endmodule

// File: tb/tb_kws_sample_ingress.sv
// tb_kws_sample_ingress: directed self-checking bench for kws_sample_ingress (CHANNELS=3, depth 8)
module tb_kws_sample_ingress;
  logic clk = 0, rst = 0;
  logic [15:0] la_sample = 0;
  logic [1:0] la_chan = 0;
  logic la_toggle = 0, la_start = 0, la_clear = 0, acc_done = 0, smp_ready = 0;
  logic [15:0] smp_data;
  logic [1:0] smp_chan;
  logic smp_valid, acc_start, busy, done_sticky, irq, ovf_flag;
  logic [3:0] fifo_level;
`ifdef KWS_INGRESS_OVFCNT_EN
  logic [7:0] ovf_count;
`endif
  int total = 0, bad = 0;

  kws_sample_ingress #(.SAMPLE_W(16), .CHANNELS(3), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .la_sample(la_sample), .la_chan(la_chan), .la_toggle(la_toggle),
    .la_start(la_start), .la_clear(la_clear), .acc_done(acc_done), .smp_data(smp_data),
    .smp_chan(smp_chan), .smp_valid(smp_valid), .smp_ready(smp_ready), .acc_start(acc_start),
    .busy(busy), .done_sticky(done_sticky), .irq(irq), .fifo_level(fifo_level),
`ifdef KWS_INGRESS_OVFCNT_EN
    .ovf_count(ovf_count),
`endif
    .ovf_flag(ovf_flag)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle(input logic [15:0] s, input logic [1:0] c);
    @(negedge clk);
    la_sample = s;
    la_chan = c;
    la_toggle = ~la_toggle;
  endtask

  task automatic start_watch(output int n, output int first);
    n = 0;
    first = 0;
    @(negedge clk);
    la_start = 1;
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      if (acc_start) begin
        n++;
        if (first == 0) first = k;
      end
    end
    @(negedge clk);
    la_start = 0;
    tick(4);
  endtask

  task automatic clear_pulse();
    @(negedge clk);
    la_clear = 1;
    tick(5);
    @(negedge clk);
    la_clear = 0;
    tick(4);
  endtask

  task automatic test_reset();
    rst = 1;
    tick(3);
    @(negedge clk);
    rst = 0;
    tick(2);
    total++; if ({smp_data, smp_chan, smp_valid, acc_start, busy, done_sticky, irq, fifo_level, ovf_flag} !== '0) begin bad++; $display("FAIL reset_outputs got=%h exp=0", {smp_data, smp_chan, smp_valid, acc_start, busy, done_sticky, irq, fifo_level, ovf_flag}); end
  endtask

  task automatic test_start();
    int n, f;
    start_watch(n, f);
    total++; if (n !== 1) begin bad++; $display("FAIL start_pulse_count got=%0d exp=1", n); end
    total++; if (f !== 3) begin bad++; $display("FAIL start_pulse_cycle got=%0d exp=3", f); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0d exp=1", busy); end
    start_watch(n, f);
    total++; if (n !== 0) begin bad++; $display("FAIL start_in_run got=%0d exp=0", n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_in_run_busy got=%0d exp=1", busy); end
  endtask

  task automatic test_stream();
    @(negedge clk);
    smp_ready = 1;
    toggle(16'h1234, 2'd1);
    tick(2);
    total++; if (smp_valid !== 1'b0) begin bad++; $display("FAIL stream_early_valid got=%0d exp=0", smp_valid); end
    tick(1);
    total++; if (smp_valid !== 1'b1) begin bad++; $display("FAIL stream_valid got=%0d exp=1", smp_valid); end
    total++; if (smp_data !== 16'h1234) begin bad++; $display("FAIL stream_data got=%h exp=1234", smp_data); end
    total++; if (smp_chan !== 2'd1) begin bad++; $display("FAIL stream_chan got=%0d exp=1", smp_chan); end
    tick(1);
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL stream_level got=%0d exp=0", fifo_level); end
    total++; if (smp_valid !== 1'b0) begin bad++; $display("FAIL stream_drained got=%0d exp=0", smp_valid); end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    smp_ready = 0;
    for (int i = 0; i < 9; i++) begin
      toggle(16'hA000 + 16'(i), 2'(i % 2));
      tick(4);
    end
    total++; if (fifo_level !== 4'd8) begin bad++; $display("FAIL ovf_level got=%0d exp=8", fifo_level); end
    total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0d exp=1", ovf_flag); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL ovf_irq got=%0d exp=1", irq); end
`ifdef KWS_INGRESS_OVFCNT_EN
    total++; if (ovf_count !== 8'd1) begin bad++; $display("FAIL ovf_count got=%0d exp=1", ovf_count); end
`endif
    @(negedge clk);
    smp_ready = 1;
    for (int i = 0; i < 8; i++) begin
      total++; if ({smp_valid, smp_chan, smp_data} !== {1'b1, 2'(i % 2), 16'hA000 + 16'(i)}) begin bad++; $display("FAIL drain_%0d got=%h exp=%h", i, {smp_valid, smp_chan, smp_data}, {1'b1, 2'(i % 2), 16'hA000 + 16'(i)}); end
      tick(1);
    end
    total++; if ({smp_valid, fifo_level} !== 5'd0) begin bad++; $display("FAIL drain_empty got=%h exp=0", {smp_valid, fifo_level}); end
    @(negedge clk);
    smp_ready = 0;
  endtask

  task automatic test_bad_chan();
    int n, f;
    clear_pulse();
    total++; if ({busy, ovf_flag, irq, fifo_level} !== 7'd0) begin bad++; $display("FAIL clear_status got=%h exp=0", {busy, ovf_flag, irq, fifo_level}); end
    toggle(16'h0BAD, 2'd0);
    tick(5);
    total++; if ({fifo_level, ovf_flag} !== 5'd0) begin bad++; $display("FAIL idle_push got=%h exp=0", {fifo_level, ovf_flag}); end
    start_watch(n, f);
    total++; if (n !== 1) begin bad++; $display("FAIL restart_pulse got=%0d exp=1", n); end
    toggle(16'h3333, 2'd3);
    tick(4);
    total++; if (fifo_level !== 4'd0) begin bad++; $display("FAIL badchan_level got=%0d exp=0", fifo_level); end
    total++; if (ovf_flag !== 1'b1) begin bad++; $display("FAIL badchan_flag got=%0d exp=1", ovf_flag); end
`ifdef KWS_INGRESS_OVFCNT_EN
    total++; if (ovf_count !== 8'd1) begin bad++; $display("FAIL badchan_count got=%0d exp=1", ovf_count); end
`endif
    toggle(16'h5555, 2'd2);
    tick(4);
    total++; if ({fifo_level, smp_chan, smp_data} !== {4'd1, 2'd2, 16'h5555}) begin bad++; $display("FAIL chan2_push got=%h exp=%h", {fifo_level, smp_chan, smp_data}, {4'd1, 2'd2, 16'h5555}); end
  endtask

  task automatic test_done();
    int n, f;
    @(negedge clk);
    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    tick(1);
    total++; if ({done_sticky, irq, busy, smp_valid} !== 4'b1100) begin bad++; $display("FAIL done_status got=%b exp=1100", {done_sticky, irq, busy, smp_valid}); end
    total++; if (fifo_level !== 4'd1) begin bad++; $display("FAIL done_keeps got=%0d exp=1", fifo_level); end
    start_watch(n, f);
    total++; if ({n[3:0], busy} !== 5'd0) begin bad++; $display("FAIL done_start_ignored got=%h exp=0", {n[3:0], busy}); end
    clear_pulse();
    total++; if ({done_sticky, irq, ovf_flag, busy, fifo_level} !== 8'd0) begin bad++; $display("FAIL done_clear got=%h exp=0", {done_sticky, irq, ovf_flag, busy, fifo_level}); end
    @(negedge clk);
    acc_done = 1;
    @(negedge clk);
    acc_done = 0;
    tick(1);
    total++; if ({done_sticky, busy} !== 2'b00) begin bad++; $display("FAIL idle_done got=%b exp=00", {done_sticky, busy}); end
    start_watch(n, f);
    total++; if ({n[3:0], busy} !== 5'b00011) begin bad++; $display("FAIL new_start got=%h exp=03", {n[3:0], busy}); end
  endtask

  task automatic test_rst_mid();
    int n, f;
    for (int i = 0; i < 5; i++) begin
      toggle(16'hC000 + 16'(i), 2'd0);
      tick(4);
    end
    total++; if (fifo_level !== 4'd5) begin bad++; $display("FAIL mid_level got=%0d exp=5", fifo_level); end
    #2;
    rst = 1;
    #1;
    total++; if ({smp_data, smp_chan, smp_valid, acc_start, busy, done_sticky, irq, fifo_level, ovf_flag} !== '0) begin bad++; $display("FAIL mid_reset got=%h exp=0", {smp_data, smp_chan, smp_valid, acc_start, busy, done_sticky, irq, fifo_level, ovf_flag}); end
    tick(2);
    @(negedge clk);
    rst = 0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      if (acc_start || busy) n++;
    end
    total++; if ({n[3:0], fifo_level} !== 8'd0) begin bad++; $display("FAIL post_reset_idle got=%h exp=0", {n[3:0], fifo_level}); end
    start_watch(n, f);
    total++; if ({n[3:0], busy} !== 5'b00011) begin bad++; $display("FAIL post_reset_start got=%h exp=03", {n[3:0], busy}); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stream();
    test_overflow();
    test_bad_chan();
    test_done();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
